amba_axi_write_arb: RTL
=======================

AMBA_AXI_WRITE_ARB -- requirements
Module: amba_axi_write_arb

Interface
Parameters:
REQ-001 SHALL have parameter TIMEOUT, default 1024, the maximum number of WAIT_RESP cycles before a forced error completion (range 2..65535).

Ports (name, direction, width, meaning):
REQ-002 SHALL provide the following ports:
- aclk  in  1  single clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 write request; held until req0_ack.
- req0_addr  in  32  requester 0 address; stable while req0_valid.
- req0_data  in  32  requester 0 data; stable while req0_valid.
- req0_ack  out  1  one-cycle completion pulse to requester 0.
- req0_resp  out  2  completion status; valid only while req0_ack=1.
- req1_valid, req1_addr, req1_data, req1_ack, req1_resp  same as the req0 ports, for requester 1.
- aacaddr  out  32  address to the AXI write engine.
- aacdata  out  32  data to the AXI write engine.
- aacaddrvalid  out  1  address strobe to the engine.
- aacdatavalid  out  1  data strobe to the engine.
- bvalid  in  1  AXI write-response valid (monitored).
- bresp  in  2  AXI write response (monitored).
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the current or last owner.
- err_count  out  8  count of non-OKAY completions.
- timeout  out  1  sticky flag, set on any TIMEOUT expiry.

Function
REQ-003 SHALL implement the FSM states IDLE, ISSUE, WAIT_RESP and RESPOND, with all outputs registered.
REQ-004 In IDLE with neither reqN_valid high, the block SHALL stay in IDLE.
REQ-005 In IDLE with exactly one reqN_valid high, the block SHALL:
- set grant=N;
- latch reqN_addr and reqN_data into aacaddr and aacdata;
- go to ISSUE.
REQ-006 In IDLE with both requests valid, the block SHALL grant the requester that is not the last served one (round-robin); last_served resets to 1, so requester 0 wins the first tie.
REQ-007 ISSUE SHALL last exactly one cycle, with aacaddrvalid=aacdatavalid=1, then go to WAIT_RESP; both strobes SHALL be 0 in every other state.
REQ-008 bvalid SHALL be ignored in IDLE, ISSUE and RESPOND.
REQ-009 In WAIT_RESP, bvalid=1 SHALL capture bresp as the completion status and move to RESPOND.
REQ-010 WAIT_RESP SHALL run a 16-bit cycle counter that clears on entry.
REQ-011 When the counter reaches TIMEOUT-1 without bvalid, the block SHALL:
- set the completion status to 2'b10;
- set timeout=1;
- go to RESPOND.
REQ-012 If bvalid arrives in the same cycle the counter reaches TIMEOUT-1, bvalid SHALL win: status=bresp and timeout is unchanged.
REQ-013 RESPOND SHALL last one cycle and SHALL:
- assert req<grant>_ack=1 with req<grant>_resp=status;
- set last_served=grant;
- return to IDLE.
REQ-014 The non-granted requester SHALL have reqN_ack=0 and reqN_resp=2'b00 throughout.
REQ-015 err_count SHALL increment in the RESPOND cycle when status != 2'b00 and SHALL saturate at 8'hFF.
REQ-016 Latency: a request seen in IDLE at cycle t SHALL produce:
- strobes at t+1;
- earliest bvalid sample at t+2;
- ack at t+3 in the best case, and at most at t+1+TIMEOUT+1.
REQ-017 A requester that drops reqN_valid mid-transaction SHALL NOT abort the transaction; its ack SHALL still be pulsed.
REQ-018 A requester whose valid is still high in the cycle after its ack SHALL be treated as a new request.
REQ-019 aacaddr and aacdata SHALL hold their latched values until the next grant.

Reset
REQ-020 When areset=1 at a clock edge, the block SHALL:
- set state=IDLE and last_served=1;
- drive grant=0, busy=0, aacaddr=0, aacdata=0, aacaddrvalid=0, aacdatavalid=0;
- drive req0_ack=0, req1_ack=0, req0_resp=00, req1_resp=00;
- set err_count=0, timeout=0, and the WAIT_RESP counter to 0.
REQ-021 Reset in any state SHALL abandon the in-flight transaction with no ack.
REQ-022 The first request SHALL be accepted in the first cycle after areset deasserts.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Single request: req0_valid=1 with addr=32'h100, data=32'hCAFE; bvalid with bresp=00 on the first WAIT_RESP cycle -> strobes one cycle with aacaddr=32'h100 and aacdata=32'hCAFE; req0_ack at t+3 with resp=00; err_count=0.
- Tie: both requests valid from reset, each completed with bresp=00 -> grant order 0,1,0,1; exactly one ack per transaction.
- Error: bresp=2'b10 on req1 -> req1_resp=10 and err_count=1; with 300 such errors, err_count=8'hFF.
- Timeout: TIMEOUT=8 and bvalid never asserted -> ack 9 cycles after the strobe cycle with resp=10, timeout=1, err_count=1; a later stray bvalid in IDLE has no effect.
- Reset: areset in WAIT_RESP -> next cycle all outputs at reset values and no ack; a pending req0 is granted in the first post-reset cycle.
- Boundary: bvalid and timeout in the same cycle -> resp=bresp and timeout stays 0.

Source files
------------

// File: rtl/amba_axi_write_arb.sv
// Two-requester round-robin arbiter in front of a single AXI write engine.
// Each grant issues one address/data strobe, then waits for bvalid or a timeout.
module amba_axi_write_arb #(
  parameter int TIMEOUT = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        req0_valid,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ack,
  output logic [1:0]  req0_resp,
  input  logic        req1_valid,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ack,
  output logic [1:0]  req1_resp,
  output logic [31:0] aacaddr,
  output logic [31:0] aacdata,
  output logic        aacaddrvalid,
  output logic        aacdatavalid,
  input  logic        bvalid,
  input  logic [1:0]  bresp,
  output logic        busy,
  output logic        grant,
  output logic [7:0]  err_count,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESPOND} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg;
  logic        last_served_reg;
  logic [15:0] wait_cnt_reg;
  logic [1:0]  status_reg;

  logic        pick_next;
  logic        done_next;
  logic [1:0]  done_resp_next;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick_next = req1_valid;
    if (req0_valid && req1_valid) begin
      pick_next = ~last_served_reg;
    end
  end

  // A response arriving on the final wait cycle takes precedence over the timeout.
  always_comb begin
    done_next      = 1'b0;
    done_resp_next = 2'b10;
    if (bvalid) begin
      done_next      = 1'b1;
      done_resp_next = bresp;
    end else if (wait_cnt_reg == WAIT_LAST) begin
      done_next = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg       <= IDLE;
      last_served_reg <= 1'b1;
      wait_cnt_reg    <= 16'd0;
      status_reg      <= 2'b00;
      grant           <= 1'b0;
      busy            <= 1'b0;
      aacaddr         <= 32'd0;
      aacdata         <= 32'd0;
      aacaddrvalid    <= 1'b0;
      aacdatavalid    <= 1'b0;
      req0_ack        <= 1'b0;
      req1_ack        <= 1'b0;
      req0_resp       <= 2'b00;
      req1_resp       <= 2'b00;
      err_count       <= 8'd0;
      timeout         <= 1'b0;
    end else begin
      aacaddrvalid <= 1'b0;
      aacdatavalid <= 1'b0;
      req0_ack     <= 1'b0;
      req1_ack     <= 1'b0;
      req0_resp    <= 2'b00;
      req1_resp    <= 2'b00;

      case (state_reg)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant        <= pick_next;
            aacaddr      <= pick_next ? req1_addr : req0_addr;
            aacdata      <= pick_next ? req1_data : req0_data;
            aacaddrvalid <= 1'b1;
            aacdatavalid <= 1'b1;
            busy         <= 1'b1;
            state_reg    <= ISSUE;
          end
        end

        ISSUE: begin
          wait_cnt_reg <= 16'd0;
          state_reg    <= WAIT_RESP;
        end

        WAIT_RESP: begin
          if (done_next) begin
            status_reg <= done_resp_next;
            if (!bvalid) begin
              timeout <= 1'b1;
            end
            if (grant) begin
              req1_ack  <= 1'b1;
              req1_resp <= done_resp_next;
            end else begin
              req0_ack  <= 1'b1;
              req0_resp <= done_resp_next;
            end
            state_reg <= RESPOND;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end

        RESPOND: begin
          last_served_reg <= grant;
          if (status_reg != 2'b00 && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
          end
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
